bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Central arbiter for the shared single-wire serial bus.
- Grants exclusive bus ownership to one of NUM_MASTERS bus masters using round-robin priority.
- Supervises ownership through the b_bus_utilizing line.
- Revokes a grant that goes unused for too long.
- Sits between the masters' b_request/b_grant pins and the bus; slave-side muxing uses b_grant_id.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- ID_WIDTH, 2, width of the granted-master index; must be at least clog2(NUM_MASTERS).
- TIMEOUT_LEN, 6, idle-grant timeout counter width in bits; timeout fires after 2^TIMEOUT_LEN-1 cycles (63 at default).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- b_request  input  NUM_MASTERS  per-master bus request, level, bit i = master i.
- b_bus_utilizing  input  1  wired-OR "bus in use" line, high while a master drives a transaction.
- b_grant  output  NUM_MASTERS  per-master grant, one-hot or zero.
- b_grant_id  output  ID_WIDTH  index of the currently or last granted master.
- b_busy  output  1  high whenever the arbiter is not IDLE.
- b_timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Clocking: single clock clk; reset is asynchronous and active-low (rstn). All outputs are registered.
- Reset (async, also mid-transaction): state=IDLE, b_grant=0, b_grant_id=0, b_busy=0, b_timeout=0, priority pointer=0, timeout counter=0. Any grant drops immediately, with no RELEASE cycle.
- States: IDLE, GRANTED, BUSY, RELEASE.
- IDLE, any b_request bit set:
  - Winner = first set bit scanning upward from the pointer, wrapping NUM_MASTERS-1 to 0.
  - Next edge: b_grant[winner]=1, b_grant_id=winner, counter=0, go to GRANTED.
  - Latency from request sampled high to grant high is 1 cycle.
- IDLE, no request: stay in IDLE.
- GRANTED:
  - Winner's request low: grant drops next edge, go to RELEASE. This has priority over all other events in the same cycle.
  - Otherwise b_bus_utilizing high: go to BUSY, counter cleared.
  - Otherwise counter increments. When the counter equals 2^TIMEOUT_LEN-1: grant drops, b_timeout pulses for 1 cycle, go to RELEASE.
- BUSY:
  - Grant held while the winner's request stays high.
  - b_bus_utilizing may toggle freely (the master's retries); there is no timeout in BUSY.
  - Winner's request low: grant drops next edge, go to RELEASE.
- RELEASE:
  - b_grant=0; pointer = (winner+1) mod NUM_MASTERS.
  - Stay in RELEASE while b_bus_utilizing is high (bus turnaround).
  - Go to IDLE on the first cycle b_bus_utilizing is low.
  - Minimum grant-to-grant gap is 2 cycles with grant low.
- Requests from non-granted masters are ignored until IDLE. Priority is re-evaluated only in IDLE.
- b_grant_id holds its last value when no grant is active.
- b_bus_utilizing high while in IDLE (a rogue master): no grant is issued until the line is low.
- At most one b_grant bit is ever high. This is asserted in simulation.

Decomposition:
- Shared package bus_pkg:
  - state encoding localparams (IDLE=2'd0, GRANTED=2'd1, BUSY=2'd2, RELEASE=2'd3);
  - clog2 function;
  - default bus timing constants.
- Sub-module rr_select:
  - combinational round-robin picker;
  - inputs: request vector, pointer;
  - outputs: winner index, found flag.

Test Plan:
- Single master: b_request=4'b0010 after reset -> b_grant=4'b0010 one cycle later, b_grant_id=1. Drop request -> grant 0 next edge, b_busy=0 two cycles later.
- Round robin: all four requests held, each master drops its request 5 cycles after being granted -> grant order 0,1,2,3,0.
- Timeout: master 2 granted, b_bus_utilizing held low -> grant revoked after 63 cycles, b_timeout high exactly 1 cycle, next grant goes to master 3 if it is requesting.
- Retry tolerance: master 0 granted, b_bus_utilizing pulses high three times across 200 cycles with the request held -> grant never drops, b_timeout stays 0.
- Turnaround: request drops while b_bus_utilizing is still high for 4 more cycles -> state stays RELEASE, no new grant until the line has been low for 1 cycle.
- Async reset mid-BUSY: rstn low at a quarter period -> b_grant=0 immediately. After release, master 0 has priority again.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Purpose  : Shared state encoding, sizing helper and default timing for the
//            serial-bus arbiter.
// Revision : 1.0
// ============================================================================
package bus_pkg;

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_GRANTED = 2'd1;
   localparam logic [1:0] c_BUSY    = 2'd2;
   localparam logic [1:0] c_RELEASE = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = c_IDLE,
      GRANTED = c_GRANTED,
      BUSY    = c_BUSY,
      RELEASE = c_RELEASE
   } state_t;

   localparam int c_DEF_NUM_MASTERS = 4;
   localparam int c_DEF_TIMEOUT_LEN = 6;

   function automatic int clog2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_select
// Purpose  : Combinational round-robin picker: first set request at or above
//            the pointer, wrapping from the top index back to zero.
// Revision : 1.0
// ============================================================================
module rr_select
   import bus_pkg::*;
#(
   parameter int NUM_MASTERS = c_DEF_NUM_MASTERS,
   parameter int ID_WIDTH    = clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] i_request,
   input  logic [ID_WIDTH-1:0]    i_pointer,
   output logic [ID_WIDTH-1:0]    o_winner,
   output logic                   o_found
);

   int w_dist;
   int w_best;

   // Each candidate's distance from the pointer (mod N); the smallest wins.
   always_comb begin
      o_winner = '0;
      o_found  = 1'b0;
      w_best   = NUM_MASTERS;
      w_dist   = 0;
      for (int j = 0; j < NUM_MASTERS; j++) begin
         w_dist = j - int'(i_pointer);
         if (w_dist < 0) begin
            w_dist = w_dist + NUM_MASTERS;
         end
         if (i_request[j] && (w_dist < w_best)) begin
            w_best   = w_dist;
            o_winner = ID_WIDTH'(j);
            o_found  = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin owner arbitration for the shared serial bus with
//            idle-grant timeout and bus turnaround supervision.
// Revision : 1.0
// ============================================================================
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int NUM_MASTERS = c_DEF_NUM_MASTERS,
   parameter int ID_WIDTH    = clog2(NUM_MASTERS),
   parameter int TIMEOUT_LEN = c_DEF_TIMEOUT_LEN
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NUM_MASTERS-1:0] b_request,
   input  logic                   b_bus_utilizing,
   output logic [NUM_MASTERS-1:0] b_grant,
   output logic [ID_WIDTH-1:0]    b_grant_id,
   output logic                   b_busy,
   output logic                   b_timeout
);

   // Revoke happens on the edge where the counter would reach all-ones.
   localparam logic [TIMEOUT_LEN-1:0] c_CNT_LAST = {{(TIMEOUT_LEN-1){1'b1}}, 1'b0};
   localparam logic [ID_WIDTH-1:0]    c_ID_LAST  = ID_WIDTH'(NUM_MASTERS - 1);
   localparam logic [NUM_MASTERS-1:0] c_ONE      = NUM_MASTERS'(1);

   state_t                 r_state;
   state_t                 w_state_nx;
   logic [NUM_MASTERS-1:0] r_grant;
   logic [NUM_MASTERS-1:0] w_grant_nx;
   logic [ID_WIDTH-1:0]    r_grant_id;
   logic [ID_WIDTH-1:0]    w_grant_id_nx;
   logic [ID_WIDTH-1:0]    r_pointer;
   logic [ID_WIDTH-1:0]    w_pointer_nx;
   logic [ID_WIDTH-1:0]    w_next_ptr;
   logic [ID_WIDTH-1:0]    w_winner;
   logic [TIMEOUT_LEN-1:0] r_count;
   logic [TIMEOUT_LEN-1:0] w_count_nx;
   logic                   r_busy;
   logic                   r_timeout;
   logic                   w_timeout_nx;
   logic                   w_found;
   logic                   w_owner_req;

   rr_select #(
      .NUM_MASTERS (NUM_MASTERS),
      .ID_WIDTH    (ID_WIDTH)
   ) u_rr_select (
      .i_request (b_request),
      .i_pointer (r_pointer),
      .o_winner  (w_winner),
      .o_found   (w_found)
   );

   assign w_owner_req = |(b_request & r_grant);
   assign w_next_ptr  = (r_grant_id == c_ID_LAST) ? '0 : r_grant_id + ID_WIDTH'(1);

   always_comb begin
      w_state_nx    = r_state;
      w_grant_nx    = r_grant;
      w_grant_id_nx = r_grant_id;
      w_pointer_nx  = r_pointer;
      w_count_nx    = r_count;
      w_timeout_nx  = 1'b0;
      case (r_state)
         IDLE: begin
            // A rogue driver holding the line blocks any new grant.
            if (w_found && !b_bus_utilizing) begin
               w_state_nx    = GRANTED;
               w_grant_nx    = c_ONE << w_winner;
               w_grant_id_nx = w_winner;
               w_count_nx    = '0;
            end
         end
         GRANTED: begin
            if (!w_owner_req) begin
               w_state_nx   = RELEASE;
               w_grant_nx   = '0;
               w_pointer_nx = w_next_ptr;
            end else if (b_bus_utilizing) begin
               w_state_nx = BUSY;
               w_count_nx = '0;
            end else if (r_count == c_CNT_LAST) begin
               w_state_nx   = RELEASE;
               w_grant_nx   = '0;
               w_pointer_nx = w_next_ptr;
               w_timeout_nx = 1'b1;
            end else begin
               w_count_nx = r_count + TIMEOUT_LEN'(1);
            end
         end
         BUSY: begin
            if (!w_owner_req) begin
               w_state_nx   = RELEASE;
               w_grant_nx   = '0;
               w_pointer_nx = w_next_ptr;
            end
         end
         RELEASE: begin
            if (!b_bus_utilizing) begin
               w_state_nx = IDLE;
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_grant_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_grant_id <= '0;
         r_pointer  <= '0;
         r_count    <= '0;
         r_busy     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_grant    <= w_grant_nx;
         r_grant_id <= w_grant_id_nx;
         r_pointer  <= w_pointer_nx;
         r_count    <= w_count_nx;
         r_busy     <= (w_state_nx != IDLE);
         r_timeout  <= w_timeout_nx;
      end
   end

   assign b_grant    = r_grant;
   assign b_grant_id = r_grant_id;
   assign b_busy     = r_busy;
   assign b_timeout  = r_timeout;

`ifndef SYNTHESIS
   a_grant_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(r_grant));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed scenarios plus random traffic against a behavioural
//            arbiter model; every cycle's outputs are compared to the model.
// Revision : 1.0
// ============================================================================
module tb_bus_arbiter;

   localparam int N     = 4;
   localparam int IDW   = 2;
   localparam int TL    = 6;
   localparam int LIMIT = (1 << TL) - 1;

   logic           clk  = 1'b0;
   logic           rstn = 1'b0;
   logic [N-1:0]   req  = '0;
   logic           util = 1'b0;
   logic [N-1:0]   grant;
   logic [IDW-1:0] gid;
   logic           busy;
   logic           tmo;

   int n_checks = 0;
   int n_err    = 0;

   bus_arbiter #(
      .NUM_MASTERS (N),
      .ID_WIDTH    (IDW),
      .TIMEOUT_LEN (TL)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .b_request       (req),
      .b_bus_utilizing (util),
      .b_grant         (grant),
      .b_grant_id      (gid),
      .b_busy          (busy),
      .b_timeout       (tmo)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: owner (-1 = none), whether the owner has used the bus,
   // idle cycles since grant, turnaround flag, and the next-priority master.
   int m_owner = -1;
   int m_id    = 0;
   int m_ptr   = 0;
   int m_wait  = 0;
   bit m_used  = 1'b0;
   bit m_turn  = 1'b0;
   bit m_to    = 1'b0;

   function automatic void model_reset();
      m_owner = -1; m_id = 0; m_ptr = 0; m_wait = 0;
      m_used = 1'b0; m_turn = 1'b0; m_to = 1'b0;
   endfunction

   function automatic void model_drop();
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_turn  = 1'b1;
   endfunction

   function automatic void model_step(input logic [N-1:0] r, input logic u);
      int c;
      m_to = 1'b0;
      if (m_turn) begin
         if (!u) m_turn = 1'b0;
      end else if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            model_drop();
         end else if (!m_used) begin
            if (u) begin
               m_used = 1'b1;
            end else begin
               m_wait++;
               if (m_wait == LIMIT) begin
                  model_drop();
                  m_to = 1'b1;
               end
            end
         end
      end else if (!u) begin
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (r[c]) begin
               m_owner = c; m_id = c; m_wait = 0; m_used = 1'b0;
               break;
            end
         end
      end
   endfunction

   logic [N-1:0] prev_grant = '0;
   bit           log_en     = 1'b0;
   int           q_order[$];

   always @(negedge clk) begin
      logic [N-1:0] eg;
      if (!rstn) model_reset();
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk("grant", 32'(grant), 32'(eg));
      chk("grant_id", 32'(gid), 32'(m_id));
      chk("busy", 32'(busy), 32'(m_owner >= 0 || m_turn));
      chk("timeout", 32'(tmo), 32'(m_to));
      if (log_en && grant != '0 && prev_grant == '0) q_order.push_back(int'(gid));
      prev_grant = grant;
      if (rstn) model_step(req, util);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; req = '0; util = 1'b0;
      tick(); tick();
      rstn = 1'b1;
   endtask

   task automatic wait_grant(input int budget);
      int k;
      k = 0;
      while (grant == '0 && k < budget) begin
         tick();
         k++;
      end
      chk("wait_grant", 32'(grant != '0), 32'(1));
   endtask

   initial begin
      int hi, pulses, drops, tos, lows, k;
      int age[N];
      int exp_order[5] = '{0, 1, 2, 3, 0};

      tick();
      chk("rst_grant", 32'(grant), 32'(0));
      chk("rst_id", 32'(gid), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_timeout", 32'(tmo), 32'(0));

      // Single master
      do_reset();
      req = 4'b0010;
      tick();
      chk("single_grant", 32'(grant), 32'(4'b0010));
      chk("single_id", 32'(gid), 32'(1));
      req = '0;
      tick();
      chk("single_drop", 32'(grant), 32'(0));
      tick();
      chk("single_busy_low", 32'(busy), 32'(0));

      // Round robin: each owner releases 5 cycles after its grant
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < N; i++) age[i] = 0;
      q_order.delete();
      log_en = 1'b1;
      for (int c = 0; c < 100 && q_order.size() < 5; c++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
               age[i]++;
               if (age[i] == 5) req[i] = 1'b0;
            end else begin
               age[i] = 0;
               req[i] = 1'b1;
            end
         end
      end
      log_en = 1'b0;
      chk("rr_count", 32'(q_order.size()), 32'(5));
      for (int i = 0; i < 5 && i < q_order.size(); i++) begin
         chk("rr_order", 32'(q_order[i]), 32'(exp_order[i]));
      end

      // Idle-grant timeout
      do_reset();
      req = 4'b1100;
      wait_grant(5);
      chk("to_first_id", 32'(gid), 32'(2));
      hi = 0;
      for (int i = 0; i < 100 && grant != '0; i++) begin
         hi++;
         tick();
      end
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         if (tmo) pulses++;
         tick();
      end
      chk("to_grant_len", 32'(hi), 32'(63));
      chk("to_pulses", 32'(pulses), 32'(1));
      wait_grant(10);
      chk("to_next_id", 32'(gid), 32'(3));

      // Retry tolerance in BUSY
      do_reset();
      req = 4'b0001;
      wait_grant(5);
      drops = 0;
      tos = 0;
      for (int i = 0; i < 200; i++) begin
         util = ((i % 70) >= 10) && ((i % 70) < 12);
         tick();
         if (grant != 4'b0001) drops++;
         if (tmo) tos++;
      end
      chk("retry_drops", 32'(drops), 32'(0));
      chk("retry_timeouts", 32'(tos), 32'(0));

      // Turnaround: line stays high after the owner releases
      do_reset();
      req = 4'b0011;
      wait_grant(5);
      chk("turn_first_id", 32'(gid), 32'(0));
      util = 1'b1;
      tick(); tick();
      req = 4'b0010;
      tick();
      lows = 0;
      k = 0;
      while (grant == '0 && k < 20) begin
         lows++;
         if (k == 3) util = 1'b0;
         tick();
         k++;
      end
      chk("turn_gap", 32'(lows), 32'(5));
      chk("turn_next_id", 32'(gid), 32'(1));

      // Asynchronous reset while BUSY
      do_reset();
      req = 4'b0100;
      wait_grant(5);
      util = 1'b1;
      tick(); tick();
      chk("ar_pre", 32'(grant), 32'(4'b0100));
      #4;
      rstn = 1'b0;
      #1;
      chk("ar_grant", 32'(grant), 32'(0));
      chk("ar_busy", 32'(busy), 32'(0));
      req = 4'b0101;
      util = 1'b0;
      tick(); tick();
      rstn = 1'b1;
      wait_grant(5);
      chk("ar_prio_id", 32'(gid), 32'(0));

      // Random traffic: alternating noisy and quiet (timeout-prone) stretches
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if (((i / 500) % 2) == 0) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 99) < 8) req[b] = ~req[b];
            util = ($urandom_range(0, 99) < 15);
         end else begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 99) < 1) req[b] = ~req[b];
            util = 1'b0;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
